// File: rtl/hc595_load_sequencer_if.sv
// Word handshake plus 74HC595 pin bundle for hc595_load_sequencer.
// slave = the sequencer, master = whoever feeds it words and watches the pins.
interface hc595_load_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser;
  logic             srclk;
  logic             rclk;
  logic             srclr_n;
  logic             oe_n;
  logic             busy;
  logic             done;

  modport master (
    output ena, in_data, in_valid,
    input  in_ready, ser, srclk, rclk, srclr_n, oe_n, busy, done
  );

  modport slave (
    input  ena, in_data, in_valid,
    output in_ready, ser, srclk, rclk, srclr_n, oe_n, busy, done
  );
endinterface

// File: rtl/hc595_load_sequencer.sv
// Serialises a captured word onto a 74HC595 chain (SER/SRCLK), then pulses RCLK.
// Pin outputs are flops loaded from the next-state decode so the 595 never sees glitches.
module hc595_load_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  hc595_load_sequencer_if.slave   bus
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {INIT, IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t           state_q, state_n;
  logic [DW-1:0]    div_q, div_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic             ser_q, srclk_q, rclk_q, srclr_n_q, oe_n_q, busy_q, done_q;
  logic             in_ready, accept, div_last, next_bit, shifting_n;

  // busy_q is a flop, so in_ready only carries ena through one AND gate.
  assign in_ready = bus.ena & ~busy_q;
  assign accept   = bus.in_valid & in_ready;
  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    sreg_n  = sreg_q;
    unique case (state_q)
      INIT: begin
        if (div_last) begin
          state_n = IDLE;
          div_n   = '0;
        end else div_n = div_q + 1'b1;
      end
      IDLE: begin
        if (accept) begin
          sreg_n  = bus.in_data;
          bit_n   = '0;
          div_n   = '0;
          state_n = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end else div_n = div_q + 1'b1;
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_n = '0;
          bit_n = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_n = LATCH;
          else begin
            sreg_n  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            state_n = SHIFT_LO;
          end
        end else div_n = div_q + 1'b1;
      end
      LATCH: begin
        if (div_last) begin
          div_n   = '0;
          state_n = DONE;
        end else div_n = div_q + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  assign next_bit   = MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0];
  assign shifting_n = (state_n == SHIFT_LO) || (state_n == SHIFT_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      div_q     <= '0;
      bit_q     <= '0;
      sreg_q    <= '0;
      ser_q     <= 1'b0;
      srclk_q   <= 1'b0;
      rclk_q    <= 1'b0;
      srclr_n_q <= 1'b0;
      oe_n_q    <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      div_q     <= div_n;
      bit_q     <= bit_n;
      sreg_q    <= sreg_n;
      ser_q     <= shifting_n & next_bit;
      srclk_q   <= (state_n == SHIFT_HI);
      rclk_q    <= (state_n == LATCH);
      srclr_n_q <= (state_n != INIT);
      // Outputs stay blanked until the first word has been latched.
      oe_n_q    <= oe_n_q & (state_n != DONE);
      busy_q    <= (state_n != IDLE);
      done_q    <= (state_n == DONE);
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ser      = ser_q;
  assign bus.srclk    = srclk_q;
  assign bus.rclk     = rclk_q;
  assign bus.srclr_n  = srclr_n_q;
  assign bus.oe_n     = oe_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_hc595_load_sequencer.sv
// Scoreboarded bench: two sequencers (MSB-first and LSB-first) on shared clk/rst.
// Accepted words push expected serial bits and accept times; the monitor pops them at srclk rises / done.
module tb_hc595_load_sequencer;
  logic clk;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;
  int   ncnt = 0;

  hc595_load_sequencer_if #(.WIDTH(8)) ifa ();
  hc595_load_sequencer_if #(.WIDTH(8)) ifb ();

  hc595_load_sequencer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  hc595_load_sequencer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ser, srclk, rclk, srclr_n, oe_n, in_ready, busy, done}
  function automatic logic [7:0] outs_a();
    return {ifa.ser, ifa.srclk, ifa.rclk, ifa.srclr_n, ifa.oe_n, ifa.in_ready, ifa.busy, ifa.done};
  endfunction
  localparam logic [7:0] RST_OUTS = 8'b0000_1010;

  // ---------------- scoreboard monitor ----------------
  logic [1:0] m_ser, m_srclk, m_rclk, m_done, m_vld, m_rdy;
  logic [7:0] m_data [2];
  assign m_ser   = {ifb.ser,      ifa.ser};
  assign m_srclk = {ifb.srclk,    ifa.srclk};
  assign m_rclk  = {ifb.rclk,     ifa.rclk};
  assign m_done  = {ifb.done,     ifa.done};
  assign m_vld   = {ifb.in_valid, ifa.in_valid};
  assign m_rdy   = {ifb.in_ready, ifa.in_ready};
  assign m_data[0] = ifa.in_data;
  assign m_data[1] = ifb.in_data;

  bit   bq [2][$];
  int   aq [2][$];
  logic prev_srclk [2];
  logic prev_rclk  [2];
  int   rises [2];
  int   rwid  [2];
  int   rclk_tot [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_srclk[d] = 1'b0; prev_rclk[d] = 1'b0;
      rises[d] = 0; rwid[d] = 0; rclk_tot[d] = 0;
    end
  end

  always @(negedge clk) begin
    ncnt++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        bq[d].delete();
        aq[d].delete();
        rises[d] = 0; rwid[d] = 0;
        prev_srclk[d] = 1'b0; prev_rclk[d] = 1'b0;
      end else begin
        if (m_vld[d] && m_rdy[d]) begin
          for (int i = 0; i < 8; i++)
            bq[d].push_back((d == 0) ? m_data[d][7-i] : m_data[d][i]);
          aq[d].push_back(ncnt);
        end
        if (m_srclk[d] && !prev_srclk[d]) begin
          chk("srclk_rclk_overlap", {31'd0, m_rclk[d]}, 32'd0);
          if (bq[d].size() == 0) chk("unexpected_srclk", 32'd1, 32'd0);
          else chk("ser_bit", {31'd0, m_ser[d]}, {31'd0, bq[d].pop_front()});
          rises[d]++;
        end
        if (m_rclk[d]) rwid[d]++;
        if (m_rclk[d] && !prev_rclk[d]) begin
          chk("srclk_rises_per_word", rises[d], 32'd8);
          rises[d] = 0;
          rclk_tot[d]++;
        end
        if (!m_rclk[d] && prev_rclk[d]) begin
          chk("rclk_width", rwid[d], 32'd2);
          rwid[d] = 0;
        end
        if (m_done[d]) begin
          if (aq[d].size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else chk("done_latency", ncnt - aq[d].pop_front(), 32'd35);
        end
        prev_srclk[d] = m_srclk[d];
        prev_rclk[d]  = m_rclk[d];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rdy(input int d);
    return (d == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [7:0] w);
    if (d == 0) begin ifa.in_valid = v; ifa.in_data = w; end
    else        begin ifb.in_valid = v; ifb.in_data = w; end
  endtask

  task automatic send(input int d, input logic [7:0] w);
    int n;
    @(posedge clk); #1;
    set_in(d, 1'b1, w);
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy(d) && n < 200);
    if (!rdy(d)) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_in(d, 1'b0, w);
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!((d == 0) ? ifa.done : ifb.done) && n < 100);
    if (n >= 100) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_and_check_init();
    int n;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); if (!ifa.srclr_n) n++; end while (!ifa.srclr_n && n < 10);
    chk("srclr_low_cycles", n, 32'd2);
    chk("idle_ready", {31'd0, ifa.in_ready}, 32'd1);
    chk("idle_busy", {31'd0, ifa.busy}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g, cnt_rdy, cnt_sr;
    rst = 1'b1;
    ifa.ena = 1'b1; ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.ena = 1'b1; ifb.in_valid = 1'b0; ifb.in_data = '0;

    // Reset values, then the post-reset clear window.
    repeat (2) @(negedge clk);
    chk("reset_outputs", {24'd0, outs_a()}, {24'd0, RST_OUTS});
    release_and_check_init();

    // MSB-first 0xA5, then outputs unblank.
    send(0, 8'hA5);
    wait_done(0);
    @(negedge clk);
    chk("oe_after_first_latch", {31'd0, ifa.oe_n}, 32'd0);

    // LSB-first 0x01 on the second instance.
    send(1, 8'h01);
    wait_done(1);

    // Back-to-back with in_valid held: second accept exactly one period later.
    @(posedge clk); #1;
    set_in(0, 1'b1, 8'h3C);
    g = 0;
    do begin @(negedge clk); g++; end while (!ifa.in_ready && g < 100);
    @(posedge clk); #1;
    ifa.in_data = 8'hC3;
    g = 0;
    do begin @(negedge clk); g++; end while (!ifa.in_ready && g < 100);
    chk("b2b_accept_gap", g, 32'd36);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    wait_done(0);

    // Input noise and ena drop mid-transfer must not disturb the word.
    send(0, 8'h5A);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      ifa.in_data  = 8'($urandom);
      ifa.in_valid = 1'($urandom);
      if (i == 10) ifa.ena = 1'b0;
    end
    ifa.in_valid = 1'b0;
    wait_done(0);

    // ena low in IDLE: offered word is held off, pins stay quiet.
    @(posedge clk); #1;
    ifa.in_valid = 1'b1; ifa.in_data = 8'h77;
    cnt_rdy = 0; cnt_sr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.in_ready) cnt_rdy++;
      if (ifa.srclk)    cnt_sr++;
    end
    chk("ena_low_ready", cnt_rdy, 32'd0);
    chk("ena_low_srclk", cnt_sr, 32'd0);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.ena = 1'b1;

    // Reset during the fourth bit: immediate reset values, no latch.
    send(0, 8'h96);
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midxfer_reset_outputs", {24'd0, outs_a()}, {24'd0, RST_OUTS});
    g = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ifa.rclk || !ifa.oe_n) g++;
    end
    chk("reset_hold_quiet", g, 32'd0);
    release_and_check_init();

    send(0, 8'hFF);
    wait_done(0);
    @(negedge clk);
    chk("oe_after_reset_xfer", {31'd0, ifa.oe_n}, 32'd0);

    repeat (5) @(negedge clk);
    chk("a_latched_words", rclk_tot[0], 32'd5);
    chk("b_latched_words", rclk_tot[1], 32'd1);
    chk("a_bits_pending", bq[0].size(), 32'd0);
    chk("a_done_pending", aq[0].size(), 32'd0);
    chk("b_bits_pending", bq[1].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
